// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store unit: access-size encodings, the
// LSU FSM state type, default legal address window and a helper returning
// the byte span of an access minus one.
// -----------------------------------------------------------------------------
package lsu_pkg;

   // Default legal byte-address window (1028 bytes, 257 words).
   localparam logic [31:0] LSU_ADDR_LO_DEFAULT = 32'h7FFF_FBFC;
   localparam logic [31:0] LSU_ADDR_HI_DEFAULT = 32'h7FFF_FFFF;

   // Access size encoding as presented on the size port.
   typedef enum logic [1:0] {
      SZ_BYTE    = 2'b00,
      SZ_HALF    = 2'b01,
      SZ_WORD    = 2'b10,
      SZ_ILLEGAL = 2'b11
   } lsu_size_e;

   // LSU control states.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_ACCESS = 2'b01,
      ST_WRITE  = 2'b10,
      ST_DONE   = 2'b11
   } lsu_state_e;

   // Number of bytes touched by an access, minus one (0 for byte, 1 half, 3 word).
   function automatic logic [1:0] lsu_size_extra(input logic [1:0] size);
      logic [1:0] extra;
      case (size)
         SZ_BYTE: extra = 2'd0;
         SZ_HALF: extra = 2'd1;
         SZ_WORD: extra = 2'd3;
         default: extra = 2'd0;
      endcase
      return extra;
   endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// -----------------------------------------------------------------------------
// lsu_byte_lane
// Purely combinational lane logic for a big-endian word memory.
//   Load path : selects the byte/half addressed by offset_i out of read_word_i
//               and sign- or zero-extends it; words pass through untouched.
//   Store path: merges the right-justified store value into read_word_i at the
//               addressed lane, preserving every other bit exactly.
// Ports
//   size_i        access size (byte/half/word)
//   offset_i      addr[1:0] of the access
//   signed_i      1 = sign-extend sub-word loads
//   read_word_i   word read from memory
//   store_data_i  store value, right-justified
//   load_data_o   formatted load result
//   merged_o      read word with store lane replaced
// -----------------------------------------------------------------------------
module lsu_byte_lane
   import lsu_pkg::*;
(
   input  logic [1:0]  size_i,
   input  logic [1:0]  offset_i,
   input  logic        signed_i,
   input  logic [31:0] read_word_i,
   input  logic [31:0] store_data_i,
   output logic [31:0] load_data_o,
   output logic [31:0] merged_o
);

   logic [7:0]  byte_s;
   logic [15:0] half_s;

   // Lane extraction: offset 0 is the most significant byte/half.
   always_comb begin
      byte_s = 8'h00;
      half_s = 16'h0000;
      case (offset_i)
         2'd0:    byte_s = read_word_i[31:24];
         2'd1:    byte_s = read_word_i[23:16];
         2'd2:    byte_s = read_word_i[15:8];
         2'd3:    byte_s = read_word_i[7:0];
         default: byte_s = 8'h00;
      endcase
      // Only addr[1] picks the half; addr[0] is either trapped or ignored upstream.
      if (offset_i[1]) begin
         half_s = read_word_i[15:0];
      end else begin
         half_s = read_word_i[31:16];
      end
   end

   // Load formatting: extend the selected lane to 32 bits.
   always_comb begin
      load_data_o = read_word_i;
      case (size_i)
         SZ_BYTE: load_data_o = signed_i ? {{24{byte_s[7]}}, byte_s}
                                         : {24'h000000, byte_s};
         SZ_HALF: load_data_o = signed_i ? {{16{half_s[15]}}, half_s}
                                         : {16'h0000, half_s};
         default: load_data_o = read_word_i;
      endcase
   end

   // Store merge: replace only the addressed lane of the read word.
   always_comb begin
      merged_o = read_word_i;
      case (size_i)
         SZ_BYTE: begin
            case (offset_i)
               2'd0:    merged_o[31:24] = store_data_i[7:0];
               2'd1:    merged_o[23:16] = store_data_i[7:0];
               2'd2:    merged_o[15:8]  = store_data_i[7:0];
               2'd3:    merged_o[7:0]   = store_data_i[7:0];
               default: merged_o        = read_word_i;
            endcase
         end
         SZ_HALF: begin
            if (offset_i[1]) begin
               merged_o[15:0] = store_data_i[15:0];
            end else begin
               merged_o[31:16] = store_data_i[15:0];
            end
         end
         default: merged_o = store_data_i;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// MEM-stage load/store unit in front of a word-only data memory (combinational
// read, negedge write). Sub-word stores are done as read-modify-write.
// Latency (req cycle = 1): load / word store -> done in cycle 3, sub-word
// store -> cycle 4, rejected request -> cycle 2 with fault and no memory access.
//
// Build option: LSU_MISALIGN_TRAP_EN
//   defined   : misaligned half/word accesses fault.
//   undefined : low address bits beyond natural alignment are ignored.
//
// Ports
//   clock, resetN          clock, async active-low reset
//   req                    request, held until done
//   isStore, size,
//   signedLoad, addr,
//   storeData              request attributes, latched in IDLE
//   busy                   high whenever not IDLE
//   done                   one-cycle completion pulse
//   loadData, fault        result, valid with done
//   memRead, memWrite      memory strobes (never both high)
//   memAddr                word-aligned memory address
//   memWriteData           word to write
//   memReadData            word read from memory
// -----------------------------------------------------------------------------
module load_store_unit
   import lsu_pkg::*;
#(
   parameter logic [31:0] ADDR_LO = LSU_ADDR_LO_DEFAULT,
   parameter logic [31:0] ADDR_HI = LSU_ADDR_HI_DEFAULT
)(
   input  logic        clock,
   input  logic        resetN,
   input  logic        req,
   input  logic        isStore,
   input  logic [1:0]  size,
   input  logic        signedLoad,
   input  logic [31:0] addr,
   input  logic [31:0] storeData,
   output logic        busy,
   output logic        done,
   output logic [31:0] loadData,
   output logic        fault,
   output logic        memRead,
   output logic        memWrite,
   output logic [31:0] memAddr,
   output logic [31:0] memWriteData,
   input  logic [31:0] memReadData
);

   lsu_state_e  state_q, state_d;
   logic        is_store_q, is_store_d;
   logic [1:0]  size_q, size_d;
   logic        signed_q, signed_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] load_data_q, load_data_d;
   logic        fault_q, fault_d;
   logic        done_q, done_d;
   logic        busy_q, busy_d;
   logic        mem_read_q, mem_read_d;
   logic        mem_write_q, mem_write_d;

   logic [32:0] last_byte_s;
   logic        below_s;
   logic        above_s;
   logic        misalign_s;
   logic        illegal_s;
   logic [31:0] lane_load_s;
   logic [31:0] lane_merge_s;

   // Legality of the incoming request; 33-bit sum so the top of the address
   // space cannot wrap into a false pass.
   assign last_byte_s = {1'b0, addr} + {31'b0, lsu_size_extra(size)};
   assign below_s     = (addr < ADDR_LO);
   assign above_s     = (last_byte_s > {1'b0, ADDR_HI});
`ifdef LSU_MISALIGN_TRAP_EN
   assign misalign_s  = ((size == SZ_HALF) && addr[0]) ||
                        ((size == SZ_WORD) && (addr[1:0] != 2'b00));
`else
   assign misalign_s  = 1'b0;
`endif
   assign illegal_s   = (size == SZ_ILLEGAL) || below_s || above_s || misalign_s;

   lsu_byte_lane u_lane (
      .size_i       (size_q),
      .offset_i     (addr_q[1:0]),
      .signed_i     (signed_q),
      .read_word_i  (memReadData),
      .store_data_i (wdata_q),
      .load_data_o  (lane_load_s),
      .merged_o     (lane_merge_s)
   );

   // Next-state, datapath and output decode; outputs are derived from the
   // next state so every port comes straight from a flop.
   always_comb begin
      state_d     = state_q;
      is_store_d  = is_store_q;
      size_d      = size_q;
      signed_d    = signed_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      load_data_d = load_data_q;
      fault_d     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (req) begin
               is_store_d = isStore;
               size_d     = size;
               signed_d   = signedLoad;
               addr_d     = addr;
               wdata_d    = storeData;
               if (illegal_s) begin
                  state_d     = ST_DONE;
                  fault_d     = 1'b1;
                  load_data_d = 32'h0000_0000;
               end else begin
                  state_d = ST_ACCESS;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ACCESS: begin
            if (!is_store_q) begin
               load_data_d = lane_load_s;
               state_d     = ST_DONE;
            end else if (size_q == SZ_WORD) begin
               state_d = ST_DONE;
            end else begin
               wdata_d = lane_merge_s;
               state_d = ST_WRITE;
            end
         end
         ST_WRITE: state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase

      busy_d      = (state_d != ST_IDLE);
      done_d      = (state_d == ST_DONE);
      // Loads and the read half of a read-modify-write both read in ACCESS.
      mem_read_d  = (state_d == ST_ACCESS) && (!is_store_d || (size_d != SZ_WORD));
      mem_write_d = ((state_d == ST_ACCESS) && is_store_d && (size_d == SZ_WORD)) ||
                    (state_d == ST_WRITE);
   end

   // State and output registers; reset clears strobes before any pending
   // negedge write can land.
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         state_q     <= ST_IDLE;
         is_store_q  <= 1'b0;
         size_q      <= 2'b00;
         signed_q    <= 1'b0;
         addr_q      <= 32'h0000_0000;
         wdata_q     <= 32'h0000_0000;
         load_data_q <= 32'h0000_0000;
         fault_q     <= 1'b0;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         is_store_q  <= is_store_d;
         size_q      <= size_d;
         signed_q    <= signed_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         load_data_q <= load_data_d;
         fault_q     <= fault_d;
         done_q      <= done_d;
         busy_q      <= busy_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
      end
   end

   assign busy         = busy_q;
   assign done         = done_q;
   assign loadData     = load_data_q;
   assign fault        = fault_q;
   assign memRead      = mem_read_q;
   assign memWrite     = mem_write_q;
   assign memAddr      = {addr_q[31:2], 2'b00};
   assign memWriteData = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
// Directed scoreboard bench: each issued request pushes its hand-computed
// expected result; a negedge monitor pops and compares on every done pulse.
// A behavioural word memory (combinational read, negedge write) sits on the
// memory port.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

   localparam logic [31:0] LO = 32'h7FFF_FBFC;
   localparam logic [31:0] HI = 32'h7FFF_FFFF;

   logic        clock = 1'b0;
   logic        resetN = 1'b0;
   logic        req = 1'b0;
   logic        isStore = 1'b0;
   logic [1:0]  size = 2'b00;
   logic        signedLoad = 1'b0;
   logic [31:0] addr = 32'h0;
   logic [31:0] storeData = 32'h0;
   logic        busy, done, fault, memRead, memWrite;
   logic [31:0] loadData, memAddr, memWriteData, memReadData;

   logic [31:0] mem [0:256];

   typedef struct {
      logic [31:0] data;
      logic        chk_data;
      logic        flt;
      int          lat;
      int          issue;
      logic        no_rd;
      string       name;
   } exp_t;

   exp_t exp_q[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   cyc = 0;
   logic rd_seen = 1'b0;

   load_store_unit dut (
      .clock(clock), .resetN(resetN), .req(req), .isStore(isStore), .size(size),
      .signedLoad(signedLoad), .addr(addr), .storeData(storeData), .busy(busy),
      .done(done), .loadData(loadData), .fault(fault), .memRead(memRead),
      .memWrite(memWrite), .memAddr(memAddr), .memWriteData(memWriteData),
      .memReadData(memReadData)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   function automatic int widx(input logic [31:0] a);
      logic [31:0] d;
      d = (a - LO) >> 2;
      return int'(d);
   endfunction

   // Word memory model.
   always_comb begin
      memReadData = 32'h0;
      if (memRead && memAddr >= LO && memAddr <= HI) memReadData = mem[widx(memAddr)];
   end

   always @(negedge clock) begin
      if (memWrite && memAddr >= LO && memAddr <= HI) mem[widx(memAddr)] <= memWriteData;
   end

   task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] expv);
      vectors++;
      if (act !== expv) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", nm, act, expv);
      end
   endtask

   // Monitor: compare each completion with the oldest expectation.
   always @(negedge clock) begin
      if (memRead && memWrite) begin
         vectors++;
         miscompares++;
         $display("FAIL strobe_overlap: memRead=1 memWrite=1 at cycle %0d", cyc);
      end
      if (done) begin
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_done: got done=1 expected no completion");
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check32({e.name, "_fault"}, {31'b0, fault}, {31'b0, e.flt});
            check32({e.name, "_latency"}, cyc - e.issue + 1, e.lat);
            if (e.chk_data) check32({e.name, "_data"}, loadData, e.data);
            if (e.no_rd) check32({e.name, "_no_memread"}, {31'b0, rd_seen}, 32'h0);
         end
      end
      if (memRead) rd_seen = 1'b1;
   end

   task automatic op(input string nm, input logic st, input logic [1:0] sz, input logic sg,
                     input logic [31:0] a, input logic [31:0] sd,
                     input logic [31:0] ed, input logic ef, input int el);
      exp_t e;
      int n;
      @(negedge clock);
      req = 1'b1; isStore = st; size = sz; signedLoad = sg; addr = a; storeData = sd;
      rd_seen = 1'b0;
      e.data = ed; e.chk_data = !st && !ef; e.flt = ef; e.lat = el;
      e.issue = cyc; e.no_rd = ef; e.name = nm;
      exp_q.push_back(e);
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (!done && n < 20);
      if (!done) begin
         vectors++;
         miscompares++;
         $display("FAIL %s_timeout: got no done expected done within 20 cycles", nm);
         void'(exp_q.pop_back());
      end
      req = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #12;
      check32("rst_busy", {31'b0, busy}, 32'h0);
      check32("rst_done", {31'b0, done}, 32'h0);
      check32("rst_fault", {31'b0, fault}, 32'h0);
      check32("rst_loaddata", loadData, 32'h0);
      check32("rst_memread", {31'b0, memRead}, 32'h0);
      check32("rst_memwrite", {31'b0, memWrite}, 32'h0);
      check32("rst_memaddr", memAddr, 32'h0);
      check32("rst_memwdata", memWriteData, 32'h0);
      @(negedge clock);
      resetN = 1'b1;

      // Word store then load.
      op("sw_c00", 1'b1, 2'b10, 1'b0, 32'h7FFF_FC00, 32'hDEAD_BEEF, 32'h0, 1'b0, 3);
      op("lw_c00", 1'b0, 2'b10, 1'b0, 32'h7FFF_FC00, 32'h0, 32'hDEAD_BEEF, 1'b0, 3);

      // Byte store read-modify-write.
      op("sw_c04", 1'b1, 2'b10, 1'b0, 32'h7FFF_FC04, 32'h1122_3344, 32'h0, 1'b0, 3);
      op("sb_c05", 1'b1, 2'b00, 1'b0, 32'h7FFF_FC05, 32'h0000_00AA, 32'h0, 1'b0, 4);
      check32("mem_c04_after_sb", mem[widx(32'h7FFF_FC04)], 32'h11AA_3344);
      op("lw_c04", 1'b0, 2'b10, 1'b0, 32'h7FFF_FC04, 32'h0, 32'h11AA_3344, 1'b0, 3);

      // Sub-word load extension.
      op("sw_c08", 1'b1, 2'b10, 1'b0, 32'h7FFF_FC08, 32'h80FF_0000, 32'h0, 1'b0, 3);
      op("lb_c08", 1'b0, 2'b00, 1'b1, 32'h7FFF_FC08, 32'h0, 32'hFFFF_FF80, 1'b0, 3);
      op("lhu_c0a", 1'b0, 2'b01, 1'b0, 32'h7FFF_FC0A, 32'h0, 32'h0000_0000, 1'b0, 3);
      op("lh_c08", 1'b0, 2'b01, 1'b1, 32'h7FFF_FC08, 32'h0, 32'hFFFF_80FF, 1'b0, 3);
      op("lbu_c09", 1'b0, 2'b00, 1'b0, 32'h7FFF_FC09, 32'h0, 32'h0000_00FF, 1'b0, 3);

      // Illegal requests.
      op("lw_low", 1'b0, 2'b10, 1'b0, 32'h0000_1000, 32'h0, 32'h0, 1'b1, 2);
      op("sz_ill", 1'b0, 2'b11, 1'b0, 32'h7FFF_FC00, 32'h0, 32'h0, 1'b1, 2);
      op("lb_below", 1'b0, 2'b00, 1'b0, 32'h7FFF_FBFB, 32'h0, 32'h0, 1'b1, 2);
`ifdef LSU_MISALIGN_TRAP_EN
      op("lw_c02", 1'b0, 2'b10, 1'b0, 32'h7FFF_FC02, 32'h0, 32'h0, 1'b1, 2);
`else
      op("lw_c02", 1'b0, 2'b10, 1'b0, 32'h7FFF_FC02, 32'h0, 32'hDEAD_BEEF, 1'b0, 3);
`endif

      // Top of the window.
      op("sw_top", 1'b1, 2'b10, 1'b0, 32'h7FFF_FFFC, 32'hA1B2_C3D4, 32'h0, 1'b0, 3);
      op("lbu_top", 1'b0, 2'b00, 1'b0, 32'h7FFF_FFFF, 32'h0, 32'h0000_00D4, 1'b0, 3);
      op("lw_over", 1'b0, 2'b10, 1'b0, 32'h7FFF_FFFD, 32'h0, 32'h0, 1'b1, 2);
      op("sh_top", 1'b1, 2'b01, 1'b0, 32'h7FFF_FFFE, 32'h0000_5566, 32'h0, 1'b0, 4);
      check32("mem_top_after_sh", mem[widx(32'h7FFF_FFFC)], 32'hA1B2_5566);

      // Reset during the write phase of a half store.
      op("sw_c0c", 1'b1, 2'b10, 1'b0, 32'h7FFF_FC0C, 32'hCAFE_F00D, 32'h0, 1'b0, 3);
      @(negedge clock);
      req = 1'b1; isStore = 1'b1; size = 2'b01; signedLoad = 1'b0;
      addr = 32'h7FFF_FC0C; storeData = 32'h0000_1234;
      @(posedge clock);
      @(posedge clock);
      #1;
      check32("wr_phase_memwrite", {31'b0, memWrite}, 32'h1);
      #1;
      resetN = 1'b0;
      #1;
      check32("rstw_busy", {31'b0, busy}, 32'h0);
      check32("rstw_memwrite", {31'b0, memWrite}, 32'h0);
      check32("rstw_memaddr", memAddr, 32'h0);
      check32("rstw_memwdata", memWriteData, 32'h0);
      @(negedge clock);
      #1;
      check32("rstw_mem_unchanged", mem[widx(32'h7FFF_FC0C)], 32'hCAFE_F00D);
      req = 1'b0;
      resetN = 1'b1;
      @(posedge clock);
      @(posedge clock);
      #1;
      check32("post_rst_idle_busy", {31'b0, busy}, 32'h0);
      check32("post_rst_idle_done", {31'b0, done}, 32'h0);
      op("lw_c0c", 1'b0, 2'b10, 1'b0, 32'h7FFF_FC0C, 32'h0, 32'hCAFE_F00D, 1'b0, 3);

      repeat (4) @(negedge clock);
      check32("scoreboard_empty", exp_q.size(), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter ADDR_LO, default 32'h7FFFFBFC, lowest legal byte address.
REQ-002 Parameter ADDR_HI, default 32'h7FFFFFFF, highest legal byte address.
REQ-003 clock  in  1  single clock; all state on posedge.
REQ-004 resetN  in  1  asynchronous, active-low reset.
REQ-005 req  in  1  pipeline MEM-stage request, held by requester until done.
REQ-006 isStore  in  1  1=store, 0=load.
REQ-007 size  in  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-008 signedLoad  in  1  1=sign-extend sub-word loads, 0=zero-extend.
REQ-009 addr  in  32  byte address.
REQ-010 storeData  in  32  store value, right-justified for sub-word.
REQ-011 busy  out  1  stall to pipeline, high whenever state != IDLE.
REQ-012 done  out  1  one-cycle completion pulse.
REQ-013 loadData  out  32  formatted load result, valid while done=1.
REQ-014 fault  out  1  valid with done; request rejected, no memory access made.
REQ-015 memRead / memWrite  out  1 each  strobes to word-only data memory (combinational read, negedge write).
REQ-016 memAddr  out  32  word-aligned address (addr & ~3).
REQ-017 memWriteData  out  32 / memReadData  in  32  word data to/from memory.

Function
REQ-018 FSM states IDLE, ACCESS, WRITE, DONE; IDLE samples req at posedge and latches isStore, size, signedLoad, addr, storeData.
REQ-019 IDLE->ACCESS on legal req; IDLE->DONE with fault=1 on illegal req (size=11, addr<ADDR_LO, addr+bytes-1>ADDR_HI, or misaligned per REQ-030).
REQ-020 ACCESS, load: memRead=1; memReadData captured and formatted at posedge; ->DONE. Latency req-to-done 3 cycles.
REQ-021 ACCESS, word store: memWrite=1, memWriteData=storeData; ->DONE. Latency 3 cycles.
REQ-022 ACCESS, sub-word store: memRead=1; read word merged with storeData lane and registered; ->WRITE; WRITE drives memWrite=1 with merged word; ->DONE. Latency 4 cycles.
REQ-023 Byte order big-endian: offset 0 = bits 31:24, half offset 0 = bits 31:16; unselected lanes preserved bit-exact on merge.
REQ-024 Sub-word loads extended to 32 bits per signedLoad; word loads unmodified.
REQ-025 DONE: done=1 exactly one cycle, loadData and fault stable; ->IDLE unconditionally.
REQ-026 memRead and memWrite never both 1; both 0 in IDLE and DONE.
REQ-027 req dropping mid-operation is ignored; operation completes. Requester drops req in done cycle; req still high in IDLE starts a new operation.

Reset
REQ-028 resetN low: state=IDLE, busy=0, done=0, fault=0, loadData=0, memRead=0, memWrite=0, memAddr=0, memWriteData=0, immediately and asynchronously.
REQ-029 Reset during WRITE drops memWrite before the negedge where possible; no pending operation resumes after reset release.

Configuration
REQ-030 LSU_MISALIGN_TRAP_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 faults. Undefined: low address bits beyond natural alignment ignored (half uses addr[1], word uses none), no fault.

Structure
REQ-031 Package lsu_pkg holds size encodings, FSM state enum, default ADDR_LO/ADDR_HI.
REQ-032 Combinational sub-module lsu_byte_lane performs lane extract/extend and store merge; FSM and registers stay in load_store_unit.

Verification
REQ-033 Word store 32'hDEADBEEF to 32'h7FFFFC00, then word load -> done on cycle 3 each, loadData=32'hDEADBEEF.
REQ-034 Preload 32'h11223344 at 32'h7FFFFC04; sb 8'hAA to 32'h7FFFFC05 -> 4-cycle latency, word becomes 32'h11AA3344.
REQ-035 Word 32'h80FF0000 at 32'h7FFFFC08: lb signed offset 0 -> 32'hFFFFFF80; lhu offset 2 -> 32'h00000000; lh offset 0 -> 32'hFFFF80FF.
REQ-036 Load from 32'h00001000 -> done after 2 cycles, fault=1, memRead never asserted.
REQ-037 Word load at 32'h7FFFFC02: with LSU_MISALIGN_TRAP_EN fault=1; without, data of 32'h7FFFFC00, fault=0.
REQ-038 resetN low during WRITE of sh -> outputs zero at once, memory word unchanged, IDLE after release.
